// File: rtl/spi_sensor_reader.sv
// spi_sensor_reader: read-only SPI master that captures a DATA_WIDTH field from a fixed sensor frame
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      frame request pulse (used only when CONTINUOUS=0)
//   sdo        serial data from the sensor
//   cs         chip select, active low, registered
//   sck        serial clock, idle low, registered
//   value      last captured data field
//   valid      one-clk pulse when value updates
//   busy       high while a frame is in flight
//   frame_err  prefix framing error flag (driven only with SPI_READER_FRAME_CHECK_EN)
//
// Build option: define SPI_READER_FRAME_CHECK_EN to flag frames whose prefix bits were not all zero.
module spi_sensor_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int PREFIX_BITS  = 3,
    parameter int POSTFIX_BITS = 5,
    parameter int SCK_HALF     = 4,
    parameter int QUERY_DELAY  = 40,
    parameter int CONTINUOUS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sdo,
    output logic                  cs,
    output logic                  sck,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  valid,
    output logic                  busy,
    output logic                  frame_err
);
    localparam int FRAME_BITS = PREFIX_BITS + DATA_WIDTH + POSTFIX_BITS;
    localparam int IDLE_CYC   = QUERY_DELAY * 2 * SCK_HALF + 1;
    localparam int BW         = $clog2(FRAME_BITS + 1);
    localparam int PW         = $clog2(SCK_HALF);
    localparam int DW         = $clog2(IDLE_CYC + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] PH_END   = PW'(SCK_HALF - 1);
    localparam logic [DW-1:0] IDLE_END = DW'(IDLE_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         ph;
    logic                  hi;
    logic [BW-1:0]         bit_cnt;
    logic [DW-1:0]         dly;
    logic [DATA_WIDTH-1:0] buffer;
    logic                  half_end, bit_end, sample, in_data;
    logic                  cs_d, sck_d, busy_d, valid_d;

    assign half_end = ph == PH_END;
    assign bit_end  = half_end && hi;
    // sck output lags hi by one flop, so this is the edge where sck goes 0->1
    assign sample   = state == S_FRAME && hi && !sck;
    assign in_data  = int'(bit_cnt) >= PREFIX_BITS && int'(bit_cnt) < PREFIX_BITS + DATA_WIDTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // The S_DONE cycle counts as the first idle clk, so the inter-frame gap is
    // IDLE_CYC in total; with no query delay S_DONE goes straight to the next frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (CONTINUOUS != 0 ? dly == IDLE_END : start) state_nxt = S_FRAME;
            S_FRAME: if (bit_end && bit_cnt == LAST_BIT) state_nxt = S_DONE;
            S_DONE:  state_nxt = (CONTINUOUS != 0 && IDLE_CYC == 1) ? S_FRAME : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cs_d    = state != S_FRAME;
        sck_d   = state == S_FRAME && hi;
        busy_d  = state == S_FRAME;
        valid_d = state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs    <= 1'b1;
            sck   <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
            value <= '0;
        end else begin
            cs    <= cs_d;
            sck   <= sck_d;
            busy  <= busy_d;
            valid <= valid_d;
            value <= valid_d ? buffer : value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= '0;
            hi      <= 1'b0;
            bit_cnt <= '0;
            dly     <= '0;
            buffer  <= '0;
        end else begin
            ph      <= state == S_FRAME && !half_end ? ph + 1'b1 : '0;
            hi      <= state == S_FRAME ? hi ^ half_end : 1'b0;
            bit_cnt <= state == S_FRAME ? bit_cnt + BW'(bit_end) : '0;
            // reset leaves dly at 0 so the first frame waits the full IDLE_CYC
            dly     <= state == S_IDLE && CONTINUOUS != 0 ? (state_nxt == S_FRAME ? '0 : dly + 1'b1)
                     : state == S_DONE ? DW'(1) : '0;
            buffer  <= sample && in_data ? DATA_WIDTH'({buffer, sdo}) : buffer;
        end
    end

`ifdef SPI_READER_FRAME_CHECK_EN
    logic pre_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pre_err   <= state == S_FRAME ? pre_err | (sample && int'(bit_cnt) < PREFIX_BITS && sdo) : 1'b0;
            frame_err <= valid_d ? pre_err : frame_err;
        end
    end
`else
    assign frame_err = 1'b0;
`endif
endmodule
